// File: rtl/sid_voice_regs.sv
// SID voice register block: bus access FSM, write-only shadowed frequency and
// pulse-width registers with atomic commit, control register, oscillator readback.
module sid_voice_regs (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        rvalid,
  output logic [15:0] freq,
  output logic [11:0] pw,
  output logic [7:0]  ctrl,
  output logic        upd,
  input  logic [23:0] wave_in,
  input  logic [11:0] noise_in
);

  localparam logic [4:0] ADDR_FREQ_LO = 5'h00;
  localparam logic [4:0] ADDR_FREQ_HI = 5'h01;
  localparam logic [4:0] ADDR_PW_LO   = 5'h02;
  localparam logic [4:0] ADDR_PW_HI   = 5'h03;
  localparam logic [4:0] ADDR_CTRL    = 5'h04;
  localparam logic [4:0] ADDR_OSC     = 5'h1B;
  localparam logic [4:0] ADDR_NOISE   = 5'h1C;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_HOLD
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic        r_we;
  logic [4:0]  r_addr;
  logic [7:0]  r_wdata;
  logic [7:0]  r_freq_lo;
  logic [7:0]  r_pw_lo;
  logic [15:0] r_freq;
  logic [11:0] r_pw;
  logic [7:0]  r_ctrl;
  logic        r_upd;
  logic [7:0]  r_rdata;
  logic        r_rvalid;

  logic        w_do_write;
  logic        w_do_read;
  logic [7:0]  w_rd_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples pre-edge values regardless of block ordering.
      r_state <= w_next_state;
    end
  end

  // A single cs assertion yields exactly one access; HOLD absorbs the rest of it.
  always_comb begin
    // NOTE: default first so no path leaves the output unassigned (no latch).
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (cs) w_next_state = ST_ACCESS;
      ST_ACCESS: w_next_state = cs ? ST_HOLD : ST_IDLE;
      ST_HOLD:   if (!cs) w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_addr  <= 5'h00;
      r_wdata <= 8'h00;
    end else if (r_state == ST_IDLE && cs) begin
      r_we    <= we;
      r_addr  <= addr;
      r_wdata <= wdata;
    end
  end

  assign w_do_write = (r_state == ST_ACCESS) &&  r_we;
  assign w_do_read  = (r_state == ST_ACCESS) && !r_we;

  // Voice registers are write-only; only the oscillator taps read back.
  always_comb begin
    w_rd_data = 8'h00;
    case (r_addr)
      ADDR_OSC:   w_rd_data = wave_in[23:16];
      ADDR_NOISE: w_rd_data = noise_in[11:4];
      default:    w_rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_freq_lo <= 8'h00;
      r_pw_lo   <= 8'h00;
      r_freq    <= 16'h0000;
      r_pw      <= 12'h000;
      r_ctrl    <= 8'h00;
      r_upd     <= 1'b0;
      r_rdata   <= 8'h00;
      r_rvalid  <= 1'b0;
    end else begin
      r_upd    <= 1'b0;
      r_rvalid <= 1'b0;
      if (w_do_write) begin
        case (r_addr)
          ADDR_FREQ_LO: r_freq_lo <= r_wdata;
          ADDR_FREQ_HI: begin
            r_freq <= {r_wdata, r_freq_lo};
            r_upd  <= 1'b1;
          end
          ADDR_PW_LO:   r_pw_lo <= r_wdata;
          ADDR_PW_HI: begin
            r_pw  <= {r_wdata[3:0], r_pw_lo};
            r_upd <= 1'b1;
          end
          ADDR_CTRL:    r_ctrl <= r_wdata;
          default:      ;
        endcase
      end
      if (w_do_read) begin
        r_rdata  <= w_rd_data;
        r_rvalid <= 1'b1;
      end
    end
  end

  assign freq   = r_freq;
  assign pw     = r_pw;
  assign ctrl   = r_ctrl;
  assign upd    = r_upd;
  assign rdata  = r_rdata;
  assign rvalid = r_rvalid;

endmodule

// File: tb/tb_sid_voice_regs.sv
// Testbench for sid_voice_regs: directed vector table, hand-built reset/hold
// sequences, then random bus traffic against a register-map reference model.
module tb_sid_voice_regs;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  addr = 5'h00;
  logic [7:0]  wdata = 8'h00;
  logic [7:0]  rdata;
  logic        rvalid;
  logic [15:0] freq;
  logic [11:0] pw;
  logic [7:0]  ctrl;
  logic        upd;
  logic [23:0] wave_in = 24'h000000;
  logic [11:0] noise_in = 12'h000;

  int n_checks = 0;
  int n_fail   = 0;

  sid_voice_regs dut (
    .clk      (clk),
    .rst      (rst),
    .cs       (cs),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .freq     (freq),
    .pw       (pw),
    .ctrl     (ctrl),
    .upd      (upd),
    .wave_in  (wave_in),
    .noise_in (noise_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic [4:0]  a;
    logic [7:0]  d;
    logic [23:0] wave;
    logic [11:0] noise;
    logic [15:0] e_freq;
    logic [11:0] e_pw;
    logic [7:0]  e_ctrl;
    logic        e_upd;
    logic        e_rv;
    logic [7:0]  e_rdata;
  } vec_t;

  vec_t vecs[16];

  // Reference model state: what the oscillator should currently be seeing.
  logic [7:0]  m_flo, m_plo, m_ctrl, m_rdata;
  logic [15:0] m_freq;
  logic [11:0] m_pw;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [15:0] f, input logic [11:0] p,
                               input logic [7:0] c, input logic u, input logic v,
                               input logic [7:0] r);
    check({tag, "_freq"}, freq, f);
    check({tag, "_pw"}, pw, p);
    check({tag, "_ctrl"}, ctrl, c);
    check({tag, "_upd"}, upd, u);
    check({tag, "_rvalid"}, rvalid, v);
    check({tag, "_rdata"}, rdata, r);
  endtask

  // Called at a falling edge; returns at the falling edge after the access
  // took effect. wdata is scrambled once the FSM should have captured it.
  task automatic drive_access(input logic w, input logic [4:0] a, input logic [7:0] d,
                              input int hold, input logic [23:0] wv, input logic [11:0] nz);
    cs = 1'b1; we = w; addr = a; wdata = d; wave_in = wv; noise_in = nz;
    @(negedge clk);
    wdata = ~d;
    if (hold == 0) cs = 1'b0;
    @(negedge clk);
  endtask

  // Keeps cs high for the remaining hold cycles; no second access may happen.
  task automatic finish_access(input int hold);
    logic [7:0] held;
    held = rdata;
    wave_in  = 24'($urandom);
    noise_in = 12'($urandom);
    for (int k = 1; k <= hold; k++) begin
      if (k == hold) cs = 1'b0;
      @(negedge clk);
      check("hold_upd", upd, 0);
      check("hold_rvalid", rvalid, 0);
      check("hold_rdata", rdata, held);
    end
    @(negedge clk);
    check("tail_upd", upd, 0);
    check("tail_rvalid", rvalid, 0);
    check("tail_rdata", rdata, held);
  endtask

  task automatic reset_pulse();
    cs = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    m_flo = 8'h00; m_plo = 8'h00; m_ctrl = 8'h00; m_rdata = 8'h00;
    m_freq = 16'h0000; m_pw = 12'h000;
  endtask

  initial begin
    logic [15:0] f_before;
    logic        e_upd, e_rv;
    logic        w;
    logic [4:0]  a;
    logic [7:0]  d;
    logic [23:0] wv;
    logic [11:0] nz;
    int          hold;

    vecs[0]  = '{1'b1, 5'h00, 8'h34, 24'h0, 12'h0,      16'h0000, 12'h000, 8'h00, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 5'h01, 8'h12, 24'h0, 12'h0,      16'h1234, 12'h000, 8'h00, 1'b1, 1'b0, 8'h00};
    vecs[2]  = '{1'b1, 5'h02, 8'hFF, 24'h0, 12'h0,      16'h1234, 12'h000, 8'h00, 1'b0, 1'b0, 8'h00};
    vecs[3]  = '{1'b1, 5'h03, 8'hAB, 24'h0, 12'h0,      16'h1234, 12'hBFF, 8'h00, 1'b1, 1'b0, 8'h00};
    vecs[4]  = '{1'b1, 5'h04, 8'h41, 24'h0, 12'h0,      16'h1234, 12'hBFF, 8'h41, 1'b0, 1'b0, 8'h00};
    vecs[5]  = '{1'b0, 5'h1B, 8'h00, 24'hA55A5A, 12'h0, 16'h1234, 12'hBFF, 8'h41, 1'b0, 1'b1, 8'hA5};
    vecs[6]  = '{1'b0, 5'h01, 8'h00, 24'hFF0000, 12'h0, 16'h1234, 12'hBFF, 8'h41, 1'b0, 1'b1, 8'h00};
    vecs[7]  = '{1'b0, 5'h1C, 8'h00, 24'h0, 12'hABC,    16'h1234, 12'hBFF, 8'h41, 1'b0, 1'b1, 8'hAB};
    vecs[8]  = '{1'b1, 5'h10, 8'hEE, 24'h0, 12'h0,      16'h1234, 12'hBFF, 8'h41, 1'b0, 1'b0, 8'hAB};
    vecs[9]  = '{1'b0, 5'h10, 8'h00, 24'hFFFFFF, 12'hFFF, 16'h1234, 12'hBFF, 8'h41, 1'b0, 1'b1, 8'h00};
    vecs[10] = '{1'b1, 5'h01, 8'h12, 24'h0, 12'h0,      16'h1234, 12'hBFF, 8'h41, 1'b1, 1'b0, 8'h00};
    vecs[11] = '{1'b1, 5'h00, 8'h9A, 24'h0, 12'h0,      16'h1234, 12'hBFF, 8'h41, 1'b0, 1'b0, 8'h00};
    vecs[12] = '{1'b1, 5'h03, 8'hF7, 24'h0, 12'h0,      16'h1234, 12'h7FF, 8'h41, 1'b1, 1'b0, 8'h00};
    vecs[13] = '{1'b1, 5'h01, 8'h5C, 24'h0, 12'h0,      16'h5C9A, 12'h7FF, 8'h41, 1'b1, 1'b0, 8'h00};
    vecs[14] = '{1'b0, 5'h1B, 8'h00, 24'h3C0000, 12'h0, 16'h5C9A, 12'h7FF, 8'h41, 1'b0, 1'b1, 8'h3C};
    vecs[15] = '{1'b1, 5'h1B, 8'h99, 24'h0, 12'h0,      16'h5C9A, 12'h7FF, 8'h41, 1'b0, 1'b0, 8'h3C};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_outputs("reset", 16'h0, 12'h0, 8'h00, 1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    // Directed vector table, one single-cycle cs access per row
    foreach (vecs[i]) begin
      drive_access(vecs[i].w, vecs[i].a, vecs[i].d, 0, vecs[i].wave, vecs[i].noise);
      check_outputs($sformatf("vec%0d", i), vecs[i].e_freq, vecs[i].e_pw, vecs[i].e_ctrl,
                    vecs[i].e_upd, vecs[i].e_rv, vecs[i].e_rdata);
      finish_access(0);
    end

    // cs held high: exactly one access per assertion
    drive_access(1'b1, 5'h04, 8'h82, 4, 24'h0, 12'h0);
    check("held_ctrl", ctrl, 8'h82);
    finish_access(4);
    check("held_ctrl_after", ctrl, 8'h82);
    drive_access(1'b1, 5'h01, 8'h21, 4, 24'h0, 12'h0);
    check("held_freq", freq, 16'h219A);
    check("held_freq_upd", upd, 1);
    finish_access(4);
    check("held_freq_after", freq, 16'h219A);
    drive_access(1'b0, 5'h1C, 8'h00, 4, 24'h0, 12'h5E1);
    check("held_read_rdata", rdata, 8'h5E);
    check("held_read_rvalid", rvalid, 1);
    finish_access(4);

    // Reset in the middle of a FREQ_HI access aborts it and clears the shadow
    reset_pulse();
    drive_access(1'b1, 5'h00, 8'h34, 0, 24'h0, 12'h0);
    finish_access(0);
    cs = 1'b1; we = 1'b1; addr = 5'h01; wdata = 8'h12;
    @(negedge clk);
    cs = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("abort_w_freq", freq, 16'h0);
    check("abort_w_upd", upd, 0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_w_freq2", freq, 16'h0);
    check("abort_w_upd2", upd, 0);
    drive_access(1'b1, 5'h01, 8'h56, 0, 24'h0, 12'h0);
    check("shadow_cleared_freq", freq, 16'h5600);
    check("shadow_cleared_upd", upd, 1);
    finish_access(0);

    // Reset in the middle of a read access: no rvalid, rdata stays cleared
    drive_access(1'b0, 5'h1C, 8'h00, 0, 24'h0, 12'hFF0);
    check("pre_abort_rdata", rdata, 8'hFF);
    finish_access(0);
    cs = 1'b1; we = 1'b0; addr = 5'h1B; wave_in = 24'hC30000;
    @(negedge clk);
    cs = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("abort_r_rvalid", rvalid, 0);
    check("abort_r_rdata", rdata, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    check("abort_r_rvalid2", rvalid, 0);
    check("abort_r_rdata2", rdata, 8'h00);

    // Reset released while cs is already high counts as a fresh assertion
    rst = 1'b1; cs = 1'b1; we = 1'b1; addr = 5'h01; wdata = 8'h77;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_cs_pre_upd", upd, 0);
    check("rst_cs_pre_freq", freq, 16'h0);
    @(negedge clk);
    check("rst_cs_freq", freq, 16'h7700);
    check("rst_cs_upd", upd, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_cs_hold_upd", upd, 0);
    end
    cs = 1'b0;
    @(negedge clk);
    check("rst_cs_end_upd", upd, 0);
    check("rst_cs_end_freq", freq, 16'h7700);

    // Random traffic against the register-map model
    reset_pulse();
    for (int it = 0; it < 250; it++) begin
      w    = 1'($urandom);
      d    = 8'($urandom);
      wv   = 24'($urandom);
      nz   = 12'($urandom);
      hold = int'($urandom_range(0, 2));
      case ($urandom % 8)
        0: a = 5'h00;
        1: a = 5'h01;
        2: a = 5'h02;
        3: a = 5'h03;
        4: a = 5'h04;
        5: a = 5'h1B;
        6: a = 5'h1C;
        default: a = 5'($urandom);
      endcase
      e_upd = 1'b0;
      e_rv  = 1'b0;
      f_before = m_freq;
      if (w) begin
        if (a == 5'h00) m_flo = d;
        if (a == 5'h02) m_plo = d;
        if (a == 5'h04) m_ctrl = d;
        if (a == 5'h01) begin m_freq = 16'(d) * 16'd256 + 16'(m_flo); e_upd = 1'b1; end
        if (a == 5'h03) begin m_pw = 12'(d % 8'd16) * 12'd256 + 12'(m_plo); e_upd = 1'b1; end
      end else begin
        e_rv = 1'b1;
        if (a == 5'h1B)      m_rdata = wv[23:16];
        else if (a == 5'h1C) m_rdata = 8'(nz / 12'd16);
        else                 m_rdata = 8'h00;
      end
      drive_access(w, a, d, hold, wv, nz);
      check_outputs($sformatf("rnd%0d", it), m_freq, m_pw, m_ctrl, e_upd, e_rv, m_rdata);
      if (f_before != m_freq && !e_upd) check("rnd_model", 1, 0);
      finish_access(hold);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
